// File: rtl/ti_sbox_pipe.sv
// ti_sbox_pipe: pipelined threshold-implementation S-box evaluator.
// Each layer is a bank of per-bit tables, each addressed by all shares except
// its own. A register after every layer stops glitches from crossing layers.
// An optional re-mask of each register uses fresh randomness.
module ti_sbox_pipe #(
  parameter int SHARES  = 3,
  parameter int W       = 4,
  parameter int STAGES  = 2,
  parameter logic [STAGES*SHARES*W*(2**((SHARES-1)*W))-1:0] LUT = '0,
  parameter int REFRESH = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SHARES*W-1:0]            in_sh,
  input  logic [(SHARES-1)*W*STAGES-1:0] rnd,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SHARES*W-1:0]            out_sh
);

  localparam int AW    = (SHARES - 1) * W;          // lookup address width
  localparam int DEPTH = 2 ** AW;                   // entries per table
  localparam int SW    = SHARES * W;                // width of one share vector
  localparam int LW    = STAGES * SHARES * W * DEPTH;
  localparam int IW    = $clog2(LW);

  logic [STAGES-1:0]         vld_q;
  logic [STAGES-1:0][SW-1:0] sh_q;
  logic [STAGES-1:0][SW-1:0] nxt;
  logic [STAGES:0][SW-1:0]   chain;   // chain[s] is what layer s reads
  logic                      advance;

  // Layer 0 reads the input port; layer s reads only register s-1.
  assign chain = {sh_q, in_sh};

  // The whole pipe moves together, or it all holds when the output is blocked.
  assign advance   = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign out_sh    = sh_q[STAGES-1];

  // Evaluate every layer's tables from the other shares, then re-mask.
  always_comb begin : p_layers
    logic [SW-1:0] raw;
    logic [AW-1:0] addr;
    logic [AW-1:0] r;
    logic [W-1:0]  acc;
    logic [IW-1:0] idx;
    int            slot;
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    nxt  = '0;
    raw  = '0;
    addr = '0;
    r    = '0;
    acc  = '0;
    idx  = '0;
    slot = 0;
    for (int s = 0; s < STAGES; s++) begin
      raw = '0;
      for (int j = 0; j < SHARES; j++) begin
        // Address = shares k != j in ascending order, lowest k in the LSBs.
        addr = '0;
        for (int k = 0; k < SHARES; k++) begin
          if (k != j) begin
            slot = (k < j) ? k : k - 1;
            addr[slot*W +: W] = chain[s][k*W +: W];
          end
        end
        for (int b = 0; b < W; b++) begin
          idx = IW'(((s * SHARES + j) * W + b) * DEPTH + int'(addr));
          raw[j*W + b] = LUT[idx];
        end
      end
      // Re-mask: the last share absorbs the XOR of all masks, so the
      // unmasked value is unchanged.
      r   = rnd[s*AW +: AW];
      acc = '0;
      nxt[s] = raw;
      if (REFRESH != 0) begin
        for (int k = 0; k < SHARES - 1; k++) begin
          nxt[s][k*W +: W] = raw[k*W +: W] ^ r[k*W +: W];
          acc = acc ^ r[k*W +: W];
        end
        nxt[s][(SHARES-1)*W +: W] = raw[(SHARES-1)*W +: W] ^ acc;
      end
    end
  end

  // Stage registers: shift valid bits and capture layer results on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      // NOTE: data registers are reset too, so out_sh reads zero during and after reset.
      sh_q  <= '0;
    end else if (advance) begin
      // NOTE: non-blocking assignments, so each stage samples its neighbour's pre-edge value.
      vld_q[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) begin
        vld_q[s] <= vld_q[s-1];
      end
      sh_q <= nxt;
    end
  end

endmodule

// File: tb/tb_ti_sbox_pipe.sv
// tb_ti_sbox_pipe: scoreboard bench for ti_sbox_pipe with the PRESENT S-box
// split into two quadratic layers, each shared directly over three shares.
module tb_ti_sbox_pipe;

  localparam int SHARES = 3;
  localparam int W      = 4;
  localparam int STAGES = 2;
  localparam int LUTW   = STAGES * SHARES * W * 256;

  // First quadratic layer G; variables x,y,z,w are bits 3..0.
  function automatic logic [3:0] g_fn(input logic [3:0] v);
    logic x, y, z, w;
    {x, y, z, w} = v;
    return {y ^ z ^ w,
            1'b1 ^ y ^ z,
            1'b1 ^ x ^ z ^ (y & w) ^ (z & w),
            1'b1 ^ w ^ (x & y) ^ (x & z) ^ (y & z)};
  endfunction

  // Second quadratic layer F, with F(G(x)) = PRESENT S(x).
  function automatic logic [3:0] f_fn(input logic [3:0] v);
    logic x, y, z, w;
    {x, y, z, w} = v;
    return {y ^ z ^ w ^ (x & w),
            x ^ (z & w),
            y ^ z ^ (x & w),
            z ^ (y & w)};
  endfunction

  function automatic logic [3:0] stage_fn(input int st, input logic [3:0] v);
    return (st == 0) ? g_fn(v) : f_fn(v);
  endfunction

  // Direct sharing of a quadratic f: share j = f(a^b) ^ f(c) ^ f(0),
  // where a, b are the two other shares and c is the one with higher index
  // for j=0 and j=2 and the lower one for j=1.
  function automatic logic [LUTW-1:0] build_lut();
    logic [LUTW-1:0] t;
    logic [3:0]      lo, hi, v;
    logic [7:0]      av;
    t = '0;
    for (int st = 0; st < STAGES; st++) begin
      for (int j = 0; j < SHARES; j++) begin
        for (int a = 0; a < 256; a++) begin
          av = 8'(a);
          lo = av[3:0];
          hi = av[7:4];
          if (j == 1) v = stage_fn(st, lo ^ hi) ^ stage_fn(st, lo) ^ stage_fn(st, 4'h0);
          else        v = stage_fn(st, lo ^ hi) ^ stage_fn(st, hi) ^ stage_fn(st, 4'h0);
          for (int b = 0; b < W; b++) t[((st * SHARES + j) * W + b) * 256 + a] = v[b];
        end
      end
    end
    return t;
  endfunction

  localparam logic [LUTW-1:0] LUT_TAB = build_lut();

  // Reference: the PRESENT S-box as a plain table.
  function automatic logic [3:0] present_s(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] xor3(input logic [11:0] sh);
    return sh[3:0] ^ sh[7:4] ^ sh[11:8];
  endfunction

  function automatic logic [11:0] share_of(input logic [3:0] x);
    logic [3:0] s0, s1;
    s0 = 4'($urandom_range(0, 15));
    s1 = 4'($urandom_range(0, 15));
    return {x ^ s0 ^ s1, s1, s0};
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready_nr;
  logic [11:0] in_sh = '0;
  logic [15:0] rnd = '0;
  logic        out_valid, out_valid_nr;
  logic        out_ready = 1'b1;
  logic [11:0] out_sh, out_sh_nr;

  always #5 clk = ~clk;

  ti_sbox_pipe #(.SHARES(SHARES), .W(W), .STAGES(STAGES), .LUT(LUT_TAB), .REFRESH(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sh(in_sh),
    .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready), .out_sh(out_sh));

  ti_sbox_pipe #(.SHARES(SHARES), .W(W), .STAGES(STAGES), .LUT(LUT_TAB), .REFRESH(0)) dut_nr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nr), .in_sh(in_sh),
    .rnd(rnd), .out_valid(out_valid_nr), .out_ready(out_ready), .out_sh(out_sh_nr));

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [3:0]  exp_q[$];
  int          pop_cyc[$];
  logic [11:0] got_sh[$];
  logic [11:0] got_nr[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard push: every accepted input queues S(x) of its unmasked value.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) exp_q.push_back(present_s(xor3(in_sh)));
  end

  // Items in flight are dropped by reset.
  always @(posedge rst) exp_q.delete();

  // Monitor: compare each accepted output against the oldest expectation.
  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst && out_valid && out_ready) begin
      got_sh.push_back(out_sh);
      pop_cyc.push_back(cyc);
      check("output_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("unmasked_out", 32'(xor3(out_sh)), 32'(e));
      end
    end
    if (!rst && out_valid_nr && out_ready) got_nr.push_back(out_sh_nr);
  end

  // One cycle of stimulus: inputs change 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic [11:0] sh, input logic [15:0] r,
                       input logic ordy);
    in_valid  = v;
    in_sh     = sh;
    rnd       = r;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] held, base, tog;
    logic [3:0]  sa, sb, d;

    // Reset state.
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sh", 32'(out_sh), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single item, latency exactly STAGES cycles.
    drive(1'b1, {4'h6, 4'h5, 4'h3}, 16'h0, 1'b1);
    check("lat_cycle1_valid", 32'(out_valid), 32'd0);
    drive(1'b0, 12'h0, 16'h0, 1'b1);
    check("lat_cycle2_valid", 32'(out_valid), 32'd1);
    check("single_unmasked", 32'(xor3(out_sh)), 32'hC);
    drive(1'b0, 12'h0, 16'h0, 1'b1);
    check("single_gone", 32'(out_valid), 32'd0);

    // Reset mid-stream with two items in flight.
    drive(1'b1, share_of(4'h7), 16'($urandom), 1'b1);
    drive(1'b1, share_of(4'h9), 16'($urandom), 1'b1);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_sh", 32'(out_sh), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("post_rst_idle", 32'(out_valid), 32'd0);
      drive(1'b0, 12'h0, 16'h0, 1'b1);
    end

    // Back-to-back: all 16 values with random sharings and masks.
    pop_cyc.delete();
    for (int x = 0; x < 16; x++) drive(1'b1, share_of(4'(x)), 16'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 12'h0, 16'h0, 1'b1);
    check("b2b_count", 32'(pop_cyc.size()), 32'd16);
    for (int i = 1; i < pop_cyc.size(); i++)
      check("b2b_consecutive", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);

    // Stall with the pipe full: everything holds, rnd is ignored.
    drive(1'b1, share_of(4'h3), 16'($urandom), 1'b1);
    drive(1'b1, share_of(4'hA), 16'($urandom), 1'b1);
    held = out_sh;
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      in_sh     = share_of(4'hE);
      rnd       = 16'($urandom);
      out_ready = 1'b0;
      #1;
      check("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_sh", 32'(out_sh), 32'(held));
    end
    check("stall_pending", 32'(exp_q.size()), 32'd2);
    drive(1'b1, share_of(4'hE), 16'($urandom), 1'b1);
    drive(1'b1, share_of(4'h5), 16'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 12'h0, 16'h0, 1'b1);
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // Refresh: same sharing twice with different masks.
    got_sh.delete();
    got_nr.delete();
    drive(1'b1, {4'h6, 4'h5, 4'h3}, 16'h0000, 1'b1);
    drive(1'b1, {4'h6, 4'h5, 4'h3}, 16'h0FFF, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 12'h0, 16'h0, 1'b1);
    check("refresh_count", 32'(got_sh.size()), 32'd2);
    check("norefresh_count", 32'(got_nr.size()), 32'd2);
    if (got_sh.size() == 2 && got_nr.size() == 2) begin
      check("refresh_shares_differ", 32'(got_sh[0] != got_sh[1]), 32'd1);
      check("refresh_unmasked_a", 32'(xor3(got_sh[0])), 32'hC);
      check("refresh_unmasked_b", 32'(xor3(got_sh[1])), 32'hC);
      check("norefresh_identical", 32'(got_nr[0]), 32'(got_nr[1]));
      check("norefresh_unmasked", 32'(xor3(got_nr[0])), 32'hC);
    end

    // Non-completeness: toggling share j leaves stage-0 share j unchanged.
    for (int j = 0; j < SHARES; j++) begin
      base = share_of(4'($urandom_range(0, 15)));
      d    = 4'($urandom_range(1, 15));
      tog  = base ^ (12'(d) << (j * W));
      drive(1'b1, base, 16'h0, 1'b1);
      sa = dut.sh_q[0][j*W +: W];
      drive(1'b1, tog, 16'h0, 1'b1);
      sb = dut.sh_q[0][j*W +: W];
      check("noncomplete_share", 32'(sb), 32'(sa));
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 12'h0, 16'h0, 1'b1);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
